// File: rtl/pxl_frame_buf_if.sv
// pxl_frame_buf_if
// Purpose : bundles the pixel-write, frame-control and read-port signals of
//           pxl_frame_buf so producer, consumer and buffer share one port.
// Signals : iFRAME_START, iPXL_VAL, iPXL, iRD_EN, iRD_ADDR, iFRAME_ACK are
//           inputs to the buffer. oRD_DATA, oRD_VAL, oFRAME_RDY, oOVERFLOW,
//           oFRAME_CNT and dbg_state (0 = FILL, 1 = HOLD) are outputs.
// Modports: slave  - the frame buffer
//           master - the producer/consumer side, e.g. a testbench
interface pxl_frame_buf_if #(
  parameter int PW = 8
);
  logic          iFRAME_START;
  logic          iPXL_VAL;
  logic [PW-1:0] iPXL;
  logic          iRD_EN;
  logic [9:0]    iRD_ADDR;
  logic          iFRAME_ACK;
  logic [PW-1:0] oRD_DATA;
  logic          oRD_VAL;
  logic          oFRAME_RDY;
  logic          oOVERFLOW;
  logic [7:0]    oFRAME_CNT;
  logic          dbg_state;

  modport slave (
    input  iFRAME_START, iPXL_VAL, iPXL, iRD_EN, iRD_ADDR, iFRAME_ACK,
    output oRD_DATA, oRD_VAL, oFRAME_RDY, oOVERFLOW, oFRAME_CNT, dbg_state
  );

  modport master (
    output iFRAME_START, iPXL_VAL, iPXL, iRD_EN, iRD_ADDR, iFRAME_ACK,
    input  oRD_DATA, oRD_VAL, oFRAME_RDY, oOVERFLOW, oFRAME_CNT, dbg_state
  );
endinterface

// File: rtl/pxl_frame_buf.sv
// pxl_frame_buf
// Purpose : double-buffered frame store between the crop/downsample stage
//           and the NN consumer. One bank fills in raster order while the
//           other is read. Completed frames are swapped in when the read bank
//           is free (or acknowledged in the same cycle); otherwise the writer
//           waits in HOLD and drops incoming pixels (sticky oOVERFLOW).
// Ports   : iCLK  - clock, rising edge
//           iRST  - asynchronous active-low reset
//           bus   - pxl_frame_buf_if.slave (pixel input, frame control,
//                   1-cycle-latency read port, status, dbg_state)
// Config  : define PXL_INVERT_EN to store (2^PW-1)-iPXL instead of iPXL.
//
// Strobe semantics: there is no back-pressure. iPXL_VAL, iRD_EN, iFRAME_ACK
// and iFRAME_START are single-cycle strobes that take effect on the edge they
// are sampled; oRD_VAL is iRD_EN delayed by one cycle and qualifies oRD_DATA.
module pxl_frame_buf #(
  parameter int NPIX = 784,
  parameter int PW   = 8
) (
  input  logic           iCLK,
  input  logic           iRST,
  pxl_frame_buf_if.slave bus
);
  localparam int AW = 10;
  localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);
  localparam logic [AW-1:0] NPIX_A   = AW'(NPIX);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          bank_q, bank_d;          // read bank; write bank is ~bank_q
  logic          frame_rdy_q, frame_rdy_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          rd_val_q, rd_val_d;
  logic [PW-1:0] rd_data_q, rd_data_d;

  logic          mem_we;
  logic          swap;
  logic [PW-1:0] wr_pxl;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  // Bank storage has no reset so it can map onto block RAM.
  logic [PW-1:0] mem0 [NPIX];
  logic [PW-1:0] mem1 [NPIX];

`ifdef PXL_INVERT_EN
  assign wr_pxl = ~bus.iPXL;              // equals (2^PW-1) - iPXL
`else
  assign wr_pxl = bus.iPXL;
`endif

  assign wr_idx = wr_cnt_q[IW-1:0];
  assign rd_idx = bus.iRD_ADDR[IW-1:0];

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    bank_d      = bank_q;
    frame_rdy_d = frame_rdy_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    mem_we      = 1'b0;
    swap        = 1'b0;

    if (bus.iFRAME_START) begin
      // Restart wins over a coincident pixel, which is dropped silently.
      state_d  = FILL;
      wr_cnt_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.iPXL_VAL) begin
            mem_we = 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
              if (!frame_rdy_q || bus.iFRAME_ACK) begin
                swap     = 1'b1;
                wr_cnt_d = '0;
              end else begin
                state_d = HOLD;
              end
            end else begin
              wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end
          if (bus.iFRAME_ACK && frame_rdy_q && !swap) begin
            frame_rdy_d = 1'b0;
          end
        end
        HOLD: begin
          if (bus.iPXL_VAL) begin
            ovf_d = 1'b1;
          end
          if (bus.iFRAME_ACK) begin
            swap     = 1'b1;
            wr_cnt_d = '0;
            state_d  = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end

    if (swap) begin
      bank_d      = ~bank_q;
      frame_rdy_d = 1'b1;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Read port reads the current (pre-swap) read bank; out-of-range is zero.
  always_comb begin
    rd_val_d  = bus.iRD_EN;
    rd_data_d = rd_data_q;
    if (bus.iRD_EN) begin
      if (bus.iRD_ADDR < NPIX_A) begin
        rd_data_d = bank_q ? mem1[rd_idx] : mem0[rd_idx];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (mem_we) begin
      if (bank_q) begin
        mem0[wr_idx] <= wr_pxl;
      end else begin
        mem1[wr_idx] <= wr_pxl;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      bank_q      <= 1'b0;
      frame_rdy_q <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      rd_val_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      bank_q      <= bank_d;
      frame_rdy_q <= frame_rdy_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      rd_val_q    <= rd_val_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign bus.oRD_DATA   = rd_data_q;
  assign bus.oRD_VAL    = rd_val_q;
  assign bus.oFRAME_RDY = frame_rdy_q;
  assign bus.oOVERFLOW  = ovf_q;
  assign bus.oFRAME_CNT = frame_cnt_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: doc/pxl_frame_buf.md
PXL_FRAME_BUF -- requirements
Module: pxl_frame_buf

Interface
REQ-001 Parameter NPIX, default 784: pixels per frame (28x28 sampled image).
REQ-002 Parameter PW, default 8: pixel width in bits.
REQ-003 iCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 iRST  input  1  reset, asynchronous assertion, active-low.
REQ-005 iFRAME_START  input  1  synchronous restart of the frame being filled.
REQ-006 iPXL_VAL  input  1  iPXL valid this cycle (sampled-pixel strobe from the crop/downsample stage).
REQ-007 iPXL  input  PW  sampled pixel, raster order.
REQ-008 iRD_EN  input  1  read request from the consumer (NN / SPART).
REQ-009 iRD_ADDR  input  10  read pixel index, 0..NPIX-1.
REQ-010 iFRAME_ACK  input  1  consumer has finished with the ready frame.
REQ-011 oRD_DATA  output  PW  read data.
REQ-012 oRD_VAL  output  1  oRD_DATA valid.
REQ-013 oFRAME_RDY  output  1  complete frame available in the read bank.
REQ-014 oOVERFLOW  output  1  sticky: pixels dropped while the write bank was held.
REQ-015 oFRAME_CNT  output  8  completed frames, modulo 256.

Function
REQ-016 Storage SHALL be two banks of NPIX x PW; one is the write bank, the other the read bank, selected by a 1-bit bank pointer.
REQ-017 The FSM SHALL have states FILL and HOLD.
REQ-018 In FILL, each iPXL_VAL cycle SHALL write iPXL to write-bank[wr_cnt] and increment wr_cnt.
REQ-019 On the write at wr_cnt==NPIX-1 with oFRAME_RDY==0 (or iFRAME_ACK==1 in that cycle), the next edge SHALL swap banks, set oFRAME_RDY=1, increment oFRAME_CNT, and clear wr_cnt to 0; the FSM stays in FILL.
REQ-020 On the write at wr_cnt==NPIX-1 with oFRAME_RDY==1 and no iFRAME_ACK, the FSM SHALL enter HOLD with wr_cnt=NPIX-1 and no swap.
REQ-021 In HOLD, iPXL_VAL pixels SHALL be discarded and SHALL set oOVERFLOW.
REQ-022 In HOLD, iFRAME_ACK SHALL cause the next edge to swap banks, keep oFRAME_RDY=1, increment oFRAME_CNT, clear wr_cnt, and return to FILL.
REQ-023 In FILL, iFRAME_ACK with oFRAME_RDY==1 and no swap that cycle SHALL clear oFRAME_RDY on the next edge; iFRAME_ACK with oFRAME_RDY==0 SHALL be ignored.
REQ-024 iFRAME_START SHALL clear wr_cnt and oOVERFLOW and force FILL on the next edge; it SHALL NOT alter the bank pointer, oFRAME_RDY or oFRAME_CNT.
REQ-025 iFRAME_START SHALL take priority over a simultaneous iPXL_VAL, which is dropped without setting oOVERFLOW.
REQ-026 Reads SHALL have 1-cycle latency: oRD_DATA = read-bank[iRD_ADDR] and oRD_VAL = iRD_EN, both registered.
REQ-027 A read issued in the swap cycle SHALL return data from the pre-swap read bank.
REQ-028 iRD_ADDR >= NPIX SHALL return oRD_DATA = 0 with oRD_VAL = 1.
REQ-029 Reads SHALL be accepted regardless of oFRAME_RDY and FSM state, and SHALL never disturb writes.
REQ-030 oFRAME_CNT SHALL wrap from 255 to 0.

Reset
REQ-031 On iRST low: state FILL, wr_cnt 0, bank pointer 0, oFRAME_RDY 0, oOVERFLOW 0, oFRAME_CNT 0, oRD_VAL 0, oRD_DATA 0.
REQ-032 Bank memory contents SHALL NOT be reset, so they can map to block RAM.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame, and the first iPXL_VAL after release SHALL write index 0.

Configuration
REQ-034 With PXL_INVERT_EN defined, each stored pixel SHALL be (2^PW-1)-iPXL, giving a light digit on a dark background for the NN.
REQ-035 Without PXL_INVERT_EN, iPXL SHALL be stored unmodified.

Verification
REQ-036 After reset, write 784 pixels with value = index[7:0] -> oFRAME_RDY=1 one cycle after the 784th write, oFRAME_CNT=1; reading addr 300 -> oRD_DATA=0x2C with oRD_VAL one cycle later.
REQ-037 With frame 1 unacked, write 784 more pixels, then 5 more -> HOLD, oOVERFLOW=1, read addr 0 still returns frame 1 data; pulse iFRAME_ACK -> swap, oFRAME_RDY stays 1, oFRAME_CNT=2.
REQ-038 Drive iFRAME_ACK in the same cycle as the 784th write while oFRAME_RDY=1 -> swap without entering HOLD, oOVERFLOW stays 0.
REQ-039 Write 100 pixels, pulse iFRAME_START together with iPXL_VAL (value 0x55), then write 784 pixels of 0xAA -> new frame ready, no 0x55 anywhere in it, index 0 = 0xAA.
REQ-040 Read addr 800 -> oRD_DATA=0; assert reset after 400 pixels -> all outputs 0, next frame completes only after 784 fresh pixels.
REQ-041 With PXL_INVERT_EN defined, iPXL=0x10 -> stored value read back as 0xEF.
